mic_queue_drain_ctrl: RTL and testbench

//   Sequences read bursts out of the microphone sample queue. Waits for the

---
 rtl/mic_queue_drain_ctrl.sv | 101 ++++++++++
 tb/tb_mic_queue_drain_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_queue_drain_ctrl.sv
// rtl/mic_queue_drain_ctrl.sv - drains BURST_LEN samples per queue interrupt onto a valid/ready stream
// Each sample is popped in FETCH, held in PRESENT until accepted, and the irq is re-armed in RELEASE.
module mic_queue_drain_ctrl #(
   parameter int DATA_W    = 16,
   parameter int BURST_LEN = 8,
   parameter int CNT_W     = 8
) (
   input  logic              sys_clk,
   input  logic              PRESETn,
   input  logic              ctrl_en,
   input  logic              q_irq,
   input  logic [DATA_W-1:0] q_data,
   output logic              q_read,
   output logic              q_enable,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  burst_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

   state_t              state_q;
   logic [CNT_W-1:0]    idx_q;
   logic [CNT_W-1:0]    burst_count_q;
   logic [DATA_W-1:0]   tx_data_q;
   logic                q_read_q;
   logic                q_enable_q;
   logic                tx_valid_q;
   logic                busy_q;

   always_ff @(posedge sys_clk or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         burst_count_q <= '0;
         tx_data_q     <= '0;
         q_read_q      <= 1'b0;
         q_enable_q    <= 1'b0;
         tx_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         q_read_q   <= 1'b0;
         q_enable_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ctrl_en && q_irq) begin
                  state_q  <= FETCH;
                  idx_q    <= '0;
                  q_read_q <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            // Head word is captured on the same edge the pop advances the queue.
            FETCH: begin
               tx_data_q  <= q_data;
               tx_valid_q <= 1'b1;
               state_q    <= PRESENT;
            end
            PRESENT: begin
               if (tx_ready) begin
                  tx_valid_q <= 1'b0;
                  if (idx_q == LAST_IDX) begin
                     state_q       <= RELEASE;
                     q_enable_q    <= 1'b1;
                     burst_count_q <= burst_count_q + 1'b1;
                  end else begin
                     idx_q    <= idx_q + 1'b1;
                     q_read_q <= 1'b1;
                     state_q  <= FETCH;
                  end
               end
            end
            RELEASE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign q_read      = q_read_q;
   assign q_enable    = q_enable_q;
   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign busy        = busy_q;
   assign burst_count = burst_count_q;

endmodule

// File: tb/tb_mic_queue_drain_ctrl.sv
// tb/tb_mic_queue_drain_ctrl.sv - self-checking bench for mic_queue_drain_ctrl
// Behavioural sample queue feeds the DUT; accepted words are checked against a scoreboard.
module tb_mic_queue_drain_ctrl;

   localparam int DW = 16;
   localparam int BL = 4;
   localparam int CW = 8;

   logic          sys_clk = 1'b0;
   logic          PRESETn;
   logic          ctrl_en;
   logic          q_irq;
   logic [DW-1:0] q_data;
   logic          q_read;
   logic          q_enable;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          busy;
   logic [CW-1:0] burst_count;

   mic_queue_drain_ctrl #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
      .sys_clk    (sys_clk),
      .PRESETn    (PRESETn),
      .ctrl_en    (ctrl_en),
      .q_irq      (q_irq),
      .q_data     (q_data),
      .q_read     (q_read),
      .q_enable   (q_enable),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .burst_count(burst_count)
   );

   always #5 sys_clk = ~sys_clk;

   logic [DW-1:0] mem [0:63];
   logic [5:0]    head;
   int            wr;
   assign q_data = mem[head];

   always @(posedge sys_clk or negedge PRESETn) begin
      if (!PRESETn) head <= '0;
      else if (q_read) head <= head + 6'd1;
   end

   int            vectors = 0;
   int            miscompares = 0;
   int            pops = 0;
   int            qes = 0;
   logic          prev_qr = 1'b0;
   logic [DW-1:0] sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge sys_clk) begin
      if (q_read) begin
         pops++;
         check("qread_gap", {31'd0, prev_qr}, 32'd0);
      end
      prev_qr = q_read;
      if (q_enable) qes++;
      if (tx_valid && tx_ready) begin
         if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
         else check("tx_data", {16'd0, tx_data}, {16'd0, sb.pop_front()});
      end
   end

   typedef struct {
      logic ctrl_en;
      logic q_irq;
      logic tx_ready;
      logic exp_qr;
      logic exp_qe;
      logic exp_tv;
      logic exp_busy;
   } vec_t;

   vec_t tbl [11];

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic load(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr % 64] = base + DW'(i);
         sb.push_back(base + DW'(i));
         wr++;
      end
   endtask

   task automatic wait_qe();
      int n = 0;
      while (!q_enable && n < 60) begin
         tick();
         n++;
      end
      check("qe_timeout", {31'd0, q_enable}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int p0, q0, n, nqe, first_qr;
      int qe_cyc [2];

      for (int i = 0; i < 64; i++) mem[i] = '0;
      wr = 0;

      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 1; i < 8; i++) begin
         if (i % 2 == 1) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
         else            tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      end
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset with irq asserted: nothing may move
      PRESETn = 1'b0; ctrl_en = 1'b1; q_irq = 1'b1; tx_ready = 1'b1;
      repeat (3) tick();
      check("rst_q_read", {31'd0, q_read}, 32'd0);
      check("rst_q_enable", {31'd0, q_enable}, 32'd0);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_tx_data", {16'd0, tx_data}, 32'd0);
      check("rst_burst_count", {24'd0, burst_count}, 32'd0);
      check("rst_pops", pops, 32'd0);
      q_irq = 1'b0; ctrl_en = 1'b0; tx_ready = 1'b0;
      PRESETn = 1'b1;
      tick();

      // Single burst, cycle-by-cycle table
      load(16'hA000, BL);
      p0 = pops;
      for (int i = 0; i < 11; i++) begin
         ctrl_en = tbl[i].ctrl_en; q_irq = tbl[i].q_irq; tx_ready = tbl[i].tx_ready;
         tick();
         check($sformatf("v%0d_q_read", i), {31'd0, q_read}, {31'd0, tbl[i].exp_qr});
         check($sformatf("v%0d_q_enable", i), {31'd0, q_enable}, {31'd0, tbl[i].exp_qe});
         check($sformatf("v%0d_tx_valid", i), {31'd0, tx_valid}, {31'd0, tbl[i].exp_tv});
         check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].exp_busy});
      end
      check("t2_pops", pops - p0, 32'd4);
      check("t2_burst_count", {24'd0, burst_count}, 32'd1);
      check("t2_sb_empty", sb.size(), 32'd0);

      // Backpressure on word 2
      load(16'hB000, BL);
      p0 = pops;
      ctrl_en = 1'b1; q_irq = 1'b1; tx_ready = 1'b1;
      tick();
      q_irq = 1'b0;
      n = 0;
      while (!((pops - p0 == 2) && tx_valid) && n < 20) begin
         tick();
         n++;
      end
      check("t3_reach_word2", {31'd0, tx_valid}, 32'd1);
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_hold_valid", {31'd0, tx_valid}, 32'd1);
         check("t3_hold_data", {16'd0, tx_data}, 32'h0000B001);
         check("t3_hold_pops", pops - p0, 32'd2);
      end
      tx_ready = 1'b1;
      wait_qe();
      tick();
      check("t3_pops", pops - p0, 32'd4);
      check("t3_burst_count", {24'd0, burst_count}, 32'd2);
      check("t3_sb_empty", sb.size(), 32'd0);

      // Back-to-back bursts with irq held high
      load(16'hE000, 2 * BL);
      p0 = pops;
      nqe = 0; first_qr = -1;
      ctrl_en = 1'b1; q_irq = 1'b1; tx_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && nqe < 2; cyc++) begin
         tick();
         if (q_enable) begin
            qe_cyc[nqe] = cyc;
            nqe++;
            if (nqe == 2) q_irq = 1'b0;
         end else if (nqe == 1 && q_read && first_qr < 0) begin
            first_qr = cyc;
         end
      end
      check("t4_two_bursts", nqe, 32'd2);
      check("t4_restart_gap", first_qr - qe_cyc[0], 32'd2);
      repeat (4) tick();
      check("t4_burst_count", {24'd0, burst_count}, 32'd4);
      check("t4_pops", pops - p0, 32'd8);
      check("t4_sb_empty", sb.size(), 32'd0);

      // ctrl_en dropped after the first pop
      load(16'hF000, BL);
      p0 = pops; q0 = qes;
      ctrl_en = 1'b1; q_irq = 1'b1; tx_ready = 1'b1;
      n = 0;
      while (!q_read && n < 10) begin
         tick();
         n++;
      end
      check("t5_first_pop", {31'd0, q_read}, 32'd1);
      ctrl_en = 1'b0;
      repeat (30) tick();
      check("t5_pops", pops - p0, 32'd4);
      check("t5_q_enables", qes - q0, 32'd1);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_burst_count", {24'd0, burst_count}, 32'd5);
      check("t5_sb_empty", sb.size(), 32'd0);
      q_irq = 1'b0;
      tick();

      // Reset pulsed while the first word is presented
      load(16'hC000, BL);
      ctrl_en = 1'b1; q_irq = 1'b1; tx_ready = 1'b0;
      tick();
      q_irq = 1'b0;
      n = 0;
      while (!tx_valid && n < 10) begin
         tick();
         n++;
      end
      check("t6_in_present", {31'd0, tx_valid}, 32'd1);
      PRESETn = 1'b0;
      #1;
      check("t6_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_q_read", {31'd0, q_read}, 32'd0);
      check("t6_rst_burst_count", {24'd0, burst_count}, 32'd0);
      sb.delete();
      wr = 0;
      tick();
      PRESETn = 1'b1;
      tx_ready = 1'b1;
      tick();
      load(16'hD000, BL);
      p0 = pops;
      q_irq = 1'b1;
      tick();
      q_irq = 1'b0;
      wait_qe();
      tick();
      check("t6_burst_count", {24'd0, burst_count}, 32'd1);
      check("t6_pops", pops - p0, 32'd4);
      check("t6_sb_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
